ntt_op_scheduler: RTL

// Command queue and sequencer for the single shared ntt_processor core.

---
 rtl/ntt_op_scheduler.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ntt_op_scheduler.sv
// rtl/ntt_op_scheduler.sv - command queue and sequencer for the shared ntt_processor core
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   cmd_valid / cmd_ready       command handshake; cmd_ready = fifo_level < DEPTH
//   cmd_mode, cmd_add_or_sub    operation select carried to the core
//   cmd_off_a/b/w               RAM offsets carried to the core
//   cmd_tag                     opaque tag echoed on completion
//   flush                       discard every queued (not in-flight) command
//   core_start                  one-cycle start pulse to the core
//   core_mode .. core_off_w     core configuration, held stable for the whole op
//   core_last                   core last_cycle, honoured only in RUN
//   done_valid/done_tag/done_err  one-cycle completion pulse, tag, watchdog flag
//   busy                        scheduler active or commands queued
//   fifo_level                  queued command count
module ntt_op_scheduler #(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1023,
  parameter int GAP     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_mode,
  input  logic                     cmd_add_or_sub,
  input  logic [ADDR_W-1:0]        cmd_off_a,
  input  logic [ADDR_W-1:0]        cmd_off_b,
  input  logic [ADDR_W-1:0]        cmd_off_w,
  input  logic [TAG_W-1:0]         cmd_tag,
  input  logic                     flush,
  output logic                     core_start,
  output logic [1:0]               core_mode,
  output logic                     core_add_or_sub,
  output logic [ADDR_W-1:0]        core_off_a,
  output logic [ADDR_W-1:0]        core_off_b,
  output logic [ADDR_W-1:0]        core_off_w,
  input  logic                     core_last,
  output logic                     done_valid,
  output logic [TAG_W-1:0]         done_tag,
  output logic                     done_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP + 1);
  localparam int ENT_W = 3 + 3 * ADDR_W + TAG_W;

  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state, state_next;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [ENT_W-1:0]  entry_in, head;
  logic [1:0]        head_mode;
  logic              head_aos;
  logic [ADDR_W-1:0] head_a, head_b, head_w;
  logic [TAG_W-1:0]  head_tag;
  logic              fifo_empty, push, pop;

  logic [TAG_W-1:0]  cur_tag;
  logic [WD_W-1:0]   wd;
  logic [GAP_W-1:0]  gap_cnt;
  logic              issue, finish, finish_err;

  assign entry_in   = {cmd_mode, cmd_add_or_sub, cmd_off_a, cmd_off_b, cmd_off_w, cmd_tag};
  assign head       = mem[rd_ptr];
  assign {head_mode, head_aos, head_a, head_b, head_w, head_tag} = head;
  assign fifo_empty = (fifo_level == '0);

  // Gated by rst_n so the ready output also reads 0 while reset is held.
  assign cmd_ready = rst_n && (fifo_level < LVL_FULL);
  assign push      = cmd_valid && cmd_ready && !flush;
  assign pop       = issue;
  assign busy      = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A flush in the cycle that would issue cancels the issue: the head is
  // still queued at that point, so it is discarded along with the rest.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    finish     = 1'b0;
    finish_err = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty && !flush) begin
          state_next = S_ISSUE;
          issue      = 1'b1;
        end
      end
      S_ISSUE: begin
        state_next = S_RUN;
      end
      S_RUN: begin
        if (core_last) begin
          state_next = S_DRAIN;
          finish     = 1'b1;
        end else if (wd == WD_LAST) begin
          state_next = S_DRAIN;
          finish     = 1'b1;
          finish_err = 1'b1;
        end
      end
      S_DRAIN: begin
        if (gap_cnt == GAP_LAST) begin
          if (!fifo_empty && !flush) begin
            state_next = S_ISSUE;
            issue      = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Storage array carries no reset; validity is tracked by fifo_level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      rd_ptr     <= wr_ptr;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_start      <= 1'b0;
      core_mode       <= '0;
      core_add_or_sub <= 1'b0;
      core_off_a      <= '0;
      core_off_b      <= '0;
      core_off_w      <= '0;
      cur_tag         <= '0;
      done_valid      <= 1'b0;
      done_err        <= 1'b0;
      done_tag        <= '0;
      wd              <= '0;
      gap_cnt         <= '0;
    end else begin
      core_start <= issue;
      done_valid <= finish;
      done_err   <= finish_err;
      if (issue) begin
        core_mode       <= head_mode;
        core_add_or_sub <= head_aos;
        core_off_a      <= head_a;
        core_off_b      <= head_b;
        core_off_w      <= head_w;
        cur_tag         <= head_tag;
      end
      if (finish) begin
        done_tag <= cur_tag;
      end
      // Watchdog counts completed RUN cycles; it stops at TIMEOUT on the
      // edge that forces the completion.
      if (issue) begin
        wd <= '0;
      end else if (state == S_RUN) begin
        wd <= wd + WD_W'(1);
      end
      if (finish) begin
        gap_cnt <= '0;
      end else if (state == S_DRAIN) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

endmodule
